// File: rtl/nc_decoder2.sv
// nc_decoder2: two-input network-coding decoder over GF(2^8).
// Inverts a 2x2 coding matrix once per generation, then decodes coded pairs
// (y1,y2) into the original pair (x1,x2) with one cycle of latency.
// Optional build macro NCDEC_SYSTEMATIC_EN: an identity matrix skips the
// inversion and reaches RUN straight from DET.
module nc_decoder2 #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iCoefValid,
    output logic       oCoefReady,
    input  logic [7:0] iA11,
    input  logic [7:0] iA12,
    input  logic [7:0] iA21,
    input  logic [7:0] iA22,
    input  logic       iSymValid,
    output logic       oSymReady,
    input  logic [7:0] iSymbol1,
    input  logic [7:0] iSymbol2,
    output logic       oValid,
    input  logic       iReady,
    output logic [7:0] oSymbol1,
    output logic [7:0] oSymbol2,
    output logic       oSingular
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DET   = 3'd1,
        S_INV   = 3'd2,
        S_SCALE = 3'd3,
        S_RUN   = 3'd4,
        S_SING  = 3'd5
    } state_t;

    // Shift-and-add GF(2^8) multiply, reducing by {1,POLY} at every shift.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[7] ? ({sh[6:0], 1'b0} ^ POLY) : {sh[6:0], 1'b0};
        end
        return acc;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] a11_q, a12_q, a21_q, a22_q;
    logic [7:0] a11_d, a12_d, a21_d, a22_d;
    logic [7:0] b11_q, b12_q, b21_q, b22_q;
    logic [7:0] b11_d, b12_d, b21_d, b22_d;
    logic [7:0] p_q, p_d, r_q, r_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] out1_q, out1_d, out2_q, out2_d;
    logic       valid_q, valid_d;
    logic       sing_q, sing_d;
    logic [7:0] det;
    logic [7:0] p_sq;
    logic       coef_acc;
    logic       sym_acc;

    // Handshake readies: coefficients only once the output stage has drained;
    // a pending coefficient load blocks new symbols.
    assign oCoefReady = ((state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_SING)) && !valid_q;
    assign oSymReady  = (state_q == S_RUN) && !iCoefValid && (!valid_q || iReady);
    assign coef_acc   = iCoefValid && oCoefReady;
    assign sym_acc    = iSymValid && oSymReady;

    assign oValid    = valid_q;
    assign oSymbol1  = out1_q;
    assign oSymbol2  = out2_q;
    assign oSingular = sing_q;

    // Next-state: matrix setup sequence plus the one-deep decoded output stage.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a11_d = a11_q;  a12_d = a12_q;  a21_d = a21_q;  a22_d = a22_q;
        b11_d = b11_q;  b12_d = b12_q;  b21_d = b21_q;  b22_d = b22_q;
        p_d     = p_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        out1_d  = out1_q;
        out2_d  = out2_q;
        valid_d = valid_q;
        sing_d  = sing_q;
        det     = gf_mul(a11_q, a22_q) ^ gf_mul(a12_q, a21_q);
        p_sq    = gf_mul(p_q, p_q);

        case (state_q)
            S_IDLE, S_RUN, S_SING: begin
                if (coef_acc) begin
                    a11_d = iA11;  a12_d = iA12;  a21_d = iA21;  a22_d = iA22;
                    sing_d  = 1'b0;
                    state_d = S_DET;
                end
            end
            S_DET: begin
`ifdef NCDEC_SYSTEMATIC_EN
                if (a11_q == 8'h01 && a12_q == 8'h00 && a21_q == 8'h00 && a22_q == 8'h01) begin
                    b11_d = 8'h01;  b12_d = 8'h00;  b21_d = 8'h00;  b22_d = 8'h01;
                    state_d = S_RUN;
                end else
`endif
                if (det == 8'h00) begin
                    sing_d  = 1'b1;
                    state_d = S_SING;
                end else begin
                    r_d     = 8'h01;
                    p_d     = det;
                    cnt_d   = 3'd0;
                    state_d = S_INV;
                end
            end
            S_INV: begin
                // Square-and-accumulate: after 7 steps r = det^(2+4+...+128) = det^254 = det^-1.
                p_d   = p_sq;
                r_d   = gf_mul(r_q, p_sq);
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) state_d = S_SCALE;
            end
            S_SCALE: begin
                b11_d = gf_mul(r_q, a22_q);
                b12_d = gf_mul(r_q, a12_q);
                b21_d = gf_mul(r_q, a21_q);
                b22_d = gf_mul(r_q, a11_q);
                state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase

        if (sym_acc) begin
            out1_d  = gf_mul(b11_q, iSymbol1) ^ gf_mul(b12_q, iSymbol2);
            out2_d  = gf_mul(b21_q, iSymbol1) ^ gf_mul(b22_q, iSymbol2);
            valid_d = 1'b1;
        end else if (iReady) begin
            valid_d = 1'b0;
        end
    end

    // State register; reset wipes the matrix so a new load is always required.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= S_IDLE;
            a11_q <= 8'h00;  a12_q <= 8'h00;  a21_q <= 8'h00;  a22_q <= 8'h00;
            b11_q <= 8'h00;  b12_q <= 8'h00;  b21_q <= 8'h00;  b22_q <= 8'h00;
            p_q     <= 8'h00;
            r_q     <= 8'h00;
            cnt_q   <= 3'd0;
            out1_q  <= 8'h00;
            out2_q  <= 8'h00;
            valid_q <= 1'b0;
            sing_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state_q <= state_d;
            a11_q <= a11_d;  a12_q <= a12_d;  a21_q <= a21_d;  a22_q <= a22_d;
            b11_q <= b11_d;  b12_q <= b12_d;  b21_q <= b21_d;  b22_q <= b22_d;
            p_q     <= p_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
            valid_q <= valid_d;
            sing_q  <= sing_d;
        end
    end

endmodule

// File: tb/tb_nc_decoder2.sv
// Self-checking bench for nc_decoder2: directed vector table, singular and
// reset corner cases, reload-while-streaming, and a randomized stalled stream
// checked against a polynomial-division GF(2^8) model.
module tb_nc_decoder2;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       iCoefValid;
    logic       oCoefReady;
    logic [7:0] iA11, iA12, iA21, iA22;
    logic       iSymValid;
    logic       oSymReady;
    logic [7:0] iSymbol1, iSymbol2;
    logic       oValid;
    logic       iReady;
    logic [7:0] oSymbol1, oSymbol2;
    logic       oSingular;

    int checks   = 0;
    int failures = 0;

    nc_decoder2 dut (
        .iCLK(iCLK), .iRST(iRST),
        .iCoefValid(iCoefValid), .oCoefReady(oCoefReady),
        .iA11(iA11), .iA12(iA12), .iA21(iA21), .iA22(iA22),
        .iSymValid(iSymValid), .oSymReady(oSymReady),
        .iSymbol1(iSymbol1), .iSymbol2(iSymbol2),
        .oValid(oValid), .iReady(iReady),
        .oSymbol1(oSymbol1), .oSymbol2(oSymbol2),
        .oSingular(oSingular)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference multiply: full carry-less product, then polynomial long division by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // Coefficient load: waits (bounded) for oCoefReady, returns at the negedge of cycle 1 after accept.
    task automatic load(input logic [7:0] a11, input logic [7:0] a12, input logic [7:0] a21, input logic [7:0] a22);
        int n = 0;
        iCoefValid = 1'b1;
        iA11 = a11;  iA12 = a12;  iA21 = a21;  iA22 = a22;
        #1;
        while (!oCoefReady && n < 50) begin
            @(negedge iCLK);
            n++;
        end
        if (n >= 50) check("coef_ready_timeout", 32'(n), 32'd0);
        @(posedge iCLK);
        @(negedge iCLK);
        iCoefValid = 1'b0;
    endtask

    // Counts cycles after accept until oSymReady rises; exp_lat 0 means do not compare.
    task automatic wait_run(input int exp_lat);
        int c = 1;
        #1;
        while (!oSymReady && c < 40) begin
            @(negedge iCLK);
            #1;
            c++;
        end
        if (exp_lat != 0) check("setup_latency", 32'(c), 32'(exp_lat));
        else if (c >= 40) check("setup_timeout", 32'(c), 32'd0);
    endtask

    // Sends one pair with iReady=1 and checks the decoded result one cycle after accept.
    task automatic send_pair(input string name, input logic [7:0] y1, input logic [7:0] y2,
                             input logic [7:0] x1, input logic [7:0] x2);
        int n = 0;
        iSymValid = 1'b1;
        iSymbol1 = y1;
        iSymbol2 = y2;
        iReady = 1'b1;
        #1;
        while (!oSymReady && n < 50) begin
            @(negedge iCLK);
            #1;
            n++;
        end
        if (n >= 50) check("sym_ready_timeout", 32'(n), 32'd0);
        @(posedge iCLK);
        @(negedge iCLK);
        iSymValid = 1'b0;
        check({name, "_valid"}, 32'(oValid), 32'd1);
        check(name, 32'({oSymbol1, oSymbol2}), 32'({x1, x2}));
    endtask

    typedef struct {
        logic [7:0] a11, a12, a21, a22;
        logic [7:0] y1, y2;
        logic [7:0] x1, x2;
        bit         ident;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] ra11, ra12, ra21, ra22;
        logic [7:0] xs1[16], xs2[16], ys1[16], ys2[16];
        logic [7:0] qx1[$], qx2[$];
        logic [7:0] h1, h2;
        logic       stalled;
        int sent, got, lat;

        vecs[0] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h12, 8'h34, 1'b1};
        vecs[1] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h26, 8'h12, 8'h12, 8'h34, 1'b0};
        vecs[2] = '{8'h53, 8'h00, 8'h00, 8'hCA, 8'h53, 8'hCA, 8'h01, 8'h01, 1'b0};
        vecs[3] = '{8'h53, 8'h00, 8'h00, 8'hCA, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h02, 8'h03, 8'h01, 8'h01, 8'h40, 8'h30, 8'h10, 8'h20, 1'b0};

        iRST = 1'b1;
        iCoefValid = 1'b0;
        iSymValid = 1'b0;
        iReady = 1'b0;
        iA11 = '0;  iA12 = '0;  iA21 = '0;  iA22 = '0;
        iSymbol1 = '0;  iSymbol2 = '0;
        repeat (3) @(negedge iCLK);
        check("reset_outputs", 32'({oValid, oSingular, oSymReady, oSymbol1, oSymbol2}), 32'd0);
        check("reset_coef_ready", 32'(oCoefReady), 32'd1);
        iRST = 1'b0;

        // Directed table: load, measure setup latency, decode one pair.
        for (int i = 0; i < 5; i++) begin
            load(vecs[i].a11, vecs[i].a12, vecs[i].a21, vecs[i].a22);
            lat = 10;
`ifdef NCDEC_SYSTEMATIC_EN
            if (vecs[i].ident) lat = 0;
`endif
            wait_run(lat);
            send_pair($sformatf("vec%0d_decode", i), vecs[i].y1, vecs[i].y2, vecs[i].x1, vecs[i].x2);
        end

        // Singular matrix: flag two cycles after accept, no symbols accepted.
        load(8'h02, 8'h04, 8'h01, 8'h02);
        check("sing_clear_in_det", 32'(oSingular), 32'd0);
        @(negedge iCLK);
        check("sing_flag", 32'(oSingular), 32'd1);
        iSymValid = 1'b1;
        lat = 0;
        repeat (12) begin
            @(negedge iCLK);
            lat += int'(oSymReady) + int'(oValid);
        end
        iSymValid = 1'b0;
        check("sing_no_symbols", 32'(lat), 32'd0);
        check("sing_sticky", 32'(oSingular), 32'd1);
        load(8'h01, 8'h01, 8'h01, 8'h00);
        check("sing_cleared_on_load", 32'(oSingular), 32'd0);
        wait_run(10);
        send_pair("after_sing_decode", 8'h26, 8'h12, 8'h12, 8'h34);

        // Randomized stream with random backpressure against the model.
        for (int m = 0; m < 2; m++) begin
            do begin
                ra11 = 8'($urandom);  ra12 = 8'($urandom);
                ra21 = 8'($urandom);  ra22 = 8'($urandom);
            end while ((ref_mul(ra11, ra22) ^ ref_mul(ra12, ra21)) == 8'h00);
            for (int k = 0; k < 16; k++) begin
                xs1[k] = 8'($urandom);
                xs2[k] = 8'($urandom);
                ys1[k] = ref_mul(ra11, xs1[k]) ^ ref_mul(ra12, xs2[k]);
                ys2[k] = ref_mul(ra21, xs1[k]) ^ ref_mul(ra22, xs2[k]);
            end
            load(ra11, ra12, ra21, ra22);
            wait_run(10);
            sent = 0;
            got = 0;
            stalled = 1'b0;
            h1 = '0;
            h2 = '0;
            for (int cyc = 0; cyc < 600 && got < 16; cyc++) begin
                @(negedge iCLK);
                if (stalled) check("stall_hold", 32'({oValid, oSymbol1, oSymbol2}), 32'({1'b1, h1, h2}));
                iReady = 1'($urandom_range(0, 1));
                iSymValid = (sent < 16) && ($urandom_range(0, 3) != 0);
                iSymbol1 = (sent < 16) ? ys1[sent] : 8'h00;
                iSymbol2 = (sent < 16) ? ys2[sent] : 8'h00;
                #1;
                stalled = oValid && !iReady;
                h1 = oSymbol1;
                h2 = oSymbol2;
                if (oValid && iReady) begin
                    if (qx1.size() == 0) begin
                        check("stream_extra_output", 32'd1, 32'd0);
                    end else begin
                        check("stream_pair", 32'({oSymbol1, oSymbol2}), 32'({qx1.pop_front(), qx2.pop_front()}));
                    end
                    got++;
                end
                if (iSymValid && oSymReady) begin
                    qx1.push_back(xs1[sent]);
                    qx2.push_back(xs2[sent]);
                    sent++;
                end
            end
            iSymValid = 1'b0;
            iReady = 1'b1;
            check("stream_count", 32'(got), 32'd16);
            @(negedge iCLK);
            check("stream_no_extra", 32'(oValid), 32'd0);
        end

        // Reset during INV cycle 4 (cycle 5 after accept), then a fresh load decodes.
        load(8'h01, 8'h01, 8'h01, 8'h00);
        repeat (4) @(negedge iCLK);
        iRST = 1'b1;
        #1;
        check("midsetup_reset_outputs", 32'({oValid, oSingular, oSymReady, oSymbol1, oSymbol2}), 32'd0);
        check("midsetup_reset_idle", 32'(oCoefReady), 32'd1);
        @(negedge iCLK);
        iRST = 1'b0;
        load(8'h53, 8'h00, 8'h00, 8'hCA);
        wait_run(10);
        send_pair("post_reset_decode", 8'h53, 8'hCA, 8'h01, 8'h01);

        // Reload while a decoded pair is stalled: the pair drains with the old matrix first.
        load(8'h01, 8'h01, 8'h01, 8'h00);
        wait_run(10);
        iSymValid = 1'b1;
        iSymbol1 = 8'h26;
        iSymbol2 = 8'h12;
        iReady = 1'b0;
        @(posedge iCLK);
        @(negedge iCLK);
        iSymValid = 1'b0;
        iCoefValid = 1'b1;
        iA11 = 8'h53;  iA12 = 8'h00;  iA21 = 8'h00;  iA22 = 8'hCA;
        #1;
        check("drain_pair", 32'({oValid, oSymbol1, oSymbol2}), 32'({1'b1, 8'h12, 8'h34}));
        check("drain_coef_blocked", 32'({oCoefReady, oSymReady}), 32'd0);
        @(negedge iCLK);
        check("drain_hold", 32'({oValid, oSymbol1, oSymbol2}), 32'({1'b1, 8'h12, 8'h34}));
        iReady = 1'b1;
        @(negedge iCLK);
        #1;
        check("drain_coef_ready", 32'({oValid, oCoefReady}), 32'b01);
        load(8'h53, 8'h00, 8'h00, 8'hCA);
        wait_run(10);
        send_pair("reload_decode", 8'h53, 8'hCA, 8'h01, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
